// File: rtl/lms_pkg.sv
// Shared types and helpers for the LMS adaptive FIR core.
package lms_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MAC  = 3'd1,
        S_ERR  = 3'd2,
        S_UPD  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Accumulator width: DATA_W x DATA_W product plus growth for TAPS additions.
    function automatic int acc_w(input int data_w, input int taps);
        return 2 * data_w + $clog2(taps);
    endfunction

    // Clamp a signed value to the range of a signed integer of the given width.
    function automatic logic signed [63:0] sat(input logic signed [63:0] value, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/lms_fir_core_mac.sv
// Shared signed multiplier and accumulator. The multiplier takes either the
// current weight (filtering) or the registered error (weight update).
module lms_mac_unit
    import lms_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 18
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sel_upd,
    input  logic                       acc_clr,
    input  logic                       acc_en,
    input  logic signed [DATA_W-1:0]   w_in,
    input  logic signed [DATA_W-1:0]   e_in,
    input  logic signed [DATA_W-1:0]   x_in,
    output logic signed [2*DATA_W-1:0] prod,
    output logic signed [ACC_W-1:0]    acc
);

    logic signed [DATA_W-1:0] op_a;

    assign op_a = sel_upd ? e_in : w_in;
    assign prod = op_a * x_in;

    // Accumulator: clear wins over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (acc_clr)
            acc <= '0;
        else if (acc_en)
            acc <= acc + ACC_W'(prod);
    end

endmodule

// File: rtl/lms_fir_core.sv
// N-tap LMS adaptive FIR with internal sequencer: one start/done transaction
// filters a new sample and, optionally, adapts all weights.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start; accepted start shifts the delay line
// MAC    | one tap per cycle: acc += w[k] * xd[k]
// ERR    | saturate y, compute e = d - y, register both
// UPD    | one tap per cycle: w[k] += (e * xd[k]) >>> (DATA_W-1+MU_SHIFT)
// DONE   | done pulse, back to IDLE
module lms_fir_core
    import lms_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int TAPS     = 4,
    parameter int MU_SHIFT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      adapt_en,
    input  logic signed [DATA_W-1:0]  x_in,
    input  logic signed [DATA_W-1:0]  d_in,
    input  logic [$clog2(TAPS)-1:0]   w_sel,
    output logic                      busy,
    output logic                      done,
    output logic signed [DATA_W-1:0]  y_out,
    output logic signed [DATA_W-1:0]  e_out,
    output logic signed [DATA_W-1:0]  w_out
);

    localparam int ACC_W = acc_w(DATA_W, TAPS);
    localparam int K_W   = $clog2(TAPS);

    state_t state, state_nx;
    logic [K_W-1:0]             k;
    logic                       last_k;
    logic                       accept;
    logic signed [DATA_W-1:0]   xd [TAPS];
    logic signed [DATA_W-1:0]   w  [TAPS];
    logic signed [DATA_W-1:0]   d_q;
    logic                       adapt_q;
    logic                       acc_clr, acc_en, sel_upd;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    y_full;
    logic signed [DATA_W-1:0]   y_sat;
    logic signed [DATA_W:0]     e_wide;
    logic signed [DATA_W-1:0]   e_sat;
    logic signed [2*DATA_W-1:0] upd_delta;
    logic signed [DATA_W-1:0]   w_new;

    assign last_k = (k == K_W'(TAPS - 1));
    assign accept = (state == S_IDLE) && start;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start)  state_nx = S_MAC;
            S_MAC:  if (last_k) state_nx = S_ERR;
            S_ERR:  state_nx = adapt_q ? S_UPD : S_DONE;
            S_UPD:  if (last_k) state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Decoded controls and status outputs.
    always_comb begin
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        sel_upd = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            S_IDLE: acc_clr = start;
            S_MAC:  begin acc_en = 1'b1; busy = 1'b1; end
            S_ERR:  busy = 1'b1;
            S_UPD:  begin sel_upd = 1'b1; busy = 1'b1; end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Tap counter; restarts at 0 for each MAC and UPD pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            k <= '0;
        else if ((state == S_MAC) || (state == S_UPD))
            k <= last_k ? '0 : k + 1'b1;
        else
            k <= '0;
    end

    // Delay line and per-transaction latches, updated only on an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) xd[i] <= '0;
            d_q     <= '0;
            adapt_q <= 1'b0;
        end else if (accept) begin
            xd[0] <= x_in;
            for (int i = 1; i < TAPS; i++) xd[i] <= xd[i-1];
            d_q     <= d_in;
            adapt_q <= adapt_en;
        end
    end

    lms_mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .clk     (clk),
        .rst     (rst),
        .sel_upd (sel_upd),
        .acc_clr (acc_clr),
        .acc_en  (acc_en),
        .w_in    (w[k]),
        .e_in    (e_out),
        .x_in    (xd[k]),
        .prod    (prod),
        .acc     (acc)
    );

    // Output scaling back to Q1.(DATA_W-1); shifts are floor (arithmetic).
    assign y_full    = acc >>> (DATA_W - 1);
    assign y_sat     = DATA_W'(sat(64'(y_full), DATA_W));
    assign e_wide    = {d_q[DATA_W-1], d_q} - {y_sat[DATA_W-1], y_sat};
    assign e_sat     = DATA_W'(sat(64'(e_wide), DATA_W));
    assign upd_delta = prod >>> (DATA_W - 1 + MU_SHIFT);
    assign w_new     = DATA_W'(sat(64'(w[k]) + 64'(upd_delta), DATA_W));

    // Result registers, loaded at the end of ERR and held until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_out <= '0;
            e_out <= '0;
        end else if (state == S_ERR) begin
            y_out <= y_sat;
            e_out <= e_sat;
        end
    end

    // Weight bank: one saturating write per UPD cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) w[i] <= '0;
        end else if (state == S_UPD) begin
            w[k] <= w_new;
        end
    end

    assign w_out = w[w_sel];

endmodule

// File: tb/tb_lms_fir_core.sv
// Directed bench for lms_fir_core; a second instance with MU_SHIFT=0 covers saturation.
module tb_lms_fir_core;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic adapt_en = 1'b0;
    logic signed [7:0] x_in = '0;
    logic signed [7:0] d_in = '0;
    logic [1:0] w_sel = '0;

    logic busy, done, busy_0, done_0;
    logic signed [7:0] y_out, e_out, w_out, y_out_0, e_out_0, w_out_0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lms_fir_core #(.DATA_W(8), .TAPS(4), .MU_SHIFT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .adapt_en(adapt_en),
        .x_in(x_in), .d_in(d_in), .w_sel(w_sel),
        .busy(busy), .done(done), .y_out(y_out), .e_out(e_out), .w_out(w_out)
    );

    lms_fir_core #(.DATA_W(8), .TAPS(4), .MU_SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .adapt_en(adapt_en),
        .x_in(x_in), .d_in(d_in), .w_sel(w_sel),
        .busy(busy_0), .done(done_0), .y_out(y_out_0), .e_out(e_out_0), .w_out(w_out_0)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One transaction; lat is the cycle index of the done pulse (edge 0 = accept), -1 on timeout.
    task automatic run_txn(input logic signed [7:0] x, input logic signed [7:0] d,
                           input logic a, output int lat);
        @(negedge clk);
        x_in = x; d_in = d; adapt_en = a; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (y_out !== 8'sd0) begin errors++; $display("FAIL reset_y got=%0d want=0", y_out); end
        checks++; if (e_out !== 8'sd0) begin errors++; $display("FAIL reset_e got=%0d want=0", e_out); end
        for (int i = 0; i < 4; i++) begin
            w_sel = 2'(i); #1;
            checks++; if (w_out !== 8'sd0) begin errors++; $display("FAIL reset_w%0d got=%0d want=0", i, w_out); end
        end
    endtask

    task automatic test_first_update();
        int lat;
        logic signed [7:0] exp_w [4];
        exp_w = '{8'sd8, 8'sd0, 8'sd0, 8'sd0};
        run_txn(8'sd64, 8'sd64, 1'b1, lat);
        checks++; if (lat !== 10) begin errors++; $display("FAIL first_latency got=%0d want=10", lat); end
        checks++; if (y_out !== 8'sd0) begin errors++; $display("FAIL first_y got=%0d want=0", y_out); end
        checks++; if (e_out !== 8'sd64) begin errors++; $display("FAIL first_e got=%0d want=64", e_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL first_busy_after got=%b want=0", busy); end
        for (int i = 0; i < 4; i++) begin
            w_sel = 2'(i); #1;
            checks++; if (w_out !== exp_w[i]) begin errors++; $display("FAIL first_w%0d got=%0d want=%0d", i, w_out, exp_w[i]); end
        end
    endtask

    task automatic test_filter_only();
        int lat;
        do_reset();
        run_txn(8'sd100, -8'sd50, 1'b0, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL filt_latency got=%0d want=6", lat); end
        checks++; if (y_out !== 8'sd0) begin errors++; $display("FAIL filt_y got=%0d want=0", y_out); end
        checks++; if (e_out !== -8'sd50) begin errors++; $display("FAIL filt_e got=%0d want=-50", e_out); end
        for (int i = 0; i < 4; i++) begin
            w_sel = 2'(i); #1;
            checks++; if (w_out !== 8'sd0) begin errors++; $display("FAIL filt_w%0d got=%0d want=0", i, w_out); end
        end
    endtask

    task automatic test_floor();
        int lat;
        logic signed [7:0] exp_w [4];
        exp_w = '{-8'sd1, 8'sd0, 8'sd0, 8'sd0};
        do_reset();
        run_txn(-8'sd1, 8'sd1, 1'b1, lat);
        checks++; if (e_out !== 8'sd1) begin errors++; $display("FAIL floor_e got=%0d want=1", e_out); end
        for (int i = 0; i < 4; i++) begin
            w_sel = 2'(i); #1;
            checks++; if (w_out !== exp_w[i]) begin errors++; $display("FAIL floor_w%0d got=%0d want=%0d", i, w_out, exp_w[i]); end
        end
    endtask

    task automatic test_saturation();
        int lat;
        logic signed [7:0] exp_w [4];
        do_reset();
        run_txn(8'sd127, 8'sd127, 1'b1, lat);
        w_sel = 2'd0; #1;
        checks++; if (w_out_0 !== 8'sd126) begin errors++; $display("FAIL sat1_w0 got=%0d want=126", w_out_0); end

        run_txn(8'sd127, 8'sd127, 1'b1, lat);
        checks++; if (y_out_0 !== 8'sd125) begin errors++; $display("FAIL sat2_y got=%0d want=125", y_out_0); end
        checks++; if (e_out_0 !== 8'sd2) begin errors++; $display("FAIL sat2_e got=%0d want=2", e_out_0); end
        exp_w = '{8'sd127, 8'sd1, 8'sd0, 8'sd0};
        for (int i = 0; i < 4; i++) begin
            w_sel = 2'(i); #1;
            checks++; if (w_out_0 !== exp_w[i]) begin errors++; $display("FAIL sat2_w%0d got=%0d want=%0d", i, w_out_0, exp_w[i]); end
        end

        run_txn(-8'sd128, 8'sd127, 1'b1, lat);
        checks++; if (y_out_0 !== -8'sd127) begin errors++; $display("FAIL sat3_y got=%0d want=-127", y_out_0); end
        checks++; if (e_out_0 !== 8'sd127) begin errors++; $display("FAIL sat3_e got=%0d want=127", e_out_0); end
        exp_w = '{8'sd0, 8'sd127, 8'sd126, 8'sd0};
        for (int i = 0; i < 4; i++) begin
            w_sel = 2'(i); #1;
            checks++; if (w_out_0 !== exp_w[i]) begin errors++; $display("FAIL sat3_w%0d got=%0d want=%0d", i, w_out_0, exp_w[i]); end
        end
    endtask

    task automatic test_start_while_busy();
        int lat;
        int n_done;
        logic signed [7:0] exp_w [4];
        do_reset();
        @(negedge clk);
        x_in = 8'sd64; d_in = 8'sd64; adapt_en = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        n_done = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = (c == 3) || (c == 9);
            if (start) x_in = (c == 3) ? 8'sd10 : 8'sd20;
            if (c == 3) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid got=%b want=1", busy); end
            end
            if (done) begin
                n_done++;
                if (lat < 0) lat = c;
            end
        end
        start = 1'b0;
        checks++; if (n_done !== 1) begin errors++; $display("FAIL busy_done_count got=%0d want=1", n_done); end
        checks++; if (lat !== 10) begin errors++; $display("FAIL busy_latency got=%0d want=10", lat); end
        checks++; if (e_out !== 8'sd64) begin errors++; $display("FAIL busy_e got=%0d want=64", e_out); end
        w_sel = 2'd0; #1;
        checks++; if (w_out !== 8'sd8) begin errors++; $display("FAIL busy_w0 got=%0d want=8", w_out); end

        // xd should now be [0, 64, 0, 0]; only w1 moves, by (64*64)>>>9 = 8.
        run_txn(8'sd0, 8'sd64, 1'b1, lat);
        checks++; if (y_out !== 8'sd0) begin errors++; $display("FAIL busy_follow_y got=%0d want=0", y_out); end
        checks++; if (e_out !== 8'sd64) begin errors++; $display("FAIL busy_follow_e got=%0d want=64", e_out); end
        exp_w = '{8'sd8, 8'sd8, 8'sd0, 8'sd0};
        for (int i = 0; i < 4; i++) begin
            w_sel = 2'(i); #1;
            checks++; if (w_out !== exp_w[i]) begin errors++; $display("FAIL busy_follow_w%0d got=%0d want=%0d", i, w_out, exp_w[i]); end
        end
    endtask

    task automatic test_reset_mid_upd();
        int lat;
        int n_done;
        logic signed [7:0] exp_w [4];
        @(negedge clk);
        x_in = 8'sd64; d_in = 8'sd64; adapt_en = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 7; c++) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b want=0", done); end
        checks++; if (y_out !== 8'sd0) begin errors++; $display("FAIL midrst_y got=%0d want=0", y_out); end
        checks++; if (e_out !== 8'sd0) begin errors++; $display("FAIL midrst_e got=%0d want=0", e_out); end
        for (int i = 0; i < 4; i++) begin
            w_sel = 2'(i); #1;
            checks++; if (w_out !== 8'sd0) begin errors++; $display("FAIL midrst_w%0d got=%0d want=0", i, w_out); end
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        checks++; if (n_done !== 0) begin errors++; $display("FAIL midrst_stray_done got=%0d want=0", n_done); end

        run_txn(8'sd64, 8'sd64, 1'b1, lat);
        checks++; if (lat !== 10) begin errors++; $display("FAIL midrst_latency got=%0d want=10", lat); end
        checks++; if (e_out !== 8'sd64) begin errors++; $display("FAIL midrst_e_after got=%0d want=64", e_out); end
        exp_w = '{8'sd8, 8'sd0, 8'sd0, 8'sd0};
        for (int i = 0; i < 4; i++) begin
            w_sel = 2'(i); #1;
            checks++; if (w_out !== exp_w[i]) begin errors++; $display("FAIL midrst_w%0d_after got=%0d want=%0d", i, w_out, exp_w[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_first_update();
        test_filter_only();
        test_floor();
        test_saturation();
        test_start_while_busy();
        test_reset_mid_upd();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
